// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron request arbiter.
package perceptron_pkg;

    localparam int N_REQ    = 2;
    localparam int ID_W     = 1;
    localparam int SAMPLE_W = 16;
    localparam int PE_W     = 8;
    localparam int WCNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Pick one requester's 16-bit sample out of the packed request bus.
    function automatic logic [SAMPLE_W-1:0] req_slice(
        input logic [N_REQ*SAMPLE_W-1:0] data,
        input logic [ID_W-1:0]           id
    );
        return data[int'(id)*SAMPLE_W +: SAMPLE_W];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic; the favour input breaks ties only.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       favour,
    input  logic       en,
    output logic [1:0] grant
);

    // A lone requester always wins; on contention the favoured one wins.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant = favour ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

endmodule

// File: rtl/perceptron_arbiter.sv
// Shares one perceptron core between two requesters: accept a sample,
// hold it on the core inputs for the settle time, return the class.
module perceptron_arbiter
    import perceptron_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*SAMPLE_W-1:0] req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [PE_W-1:0]           pe_inputs1,
    output logic [PE_W-1:0]           pe_inputs2,
    input  logic                      pe_class,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_class,
    input  logic                      rsp_ready,
    output logic                      busy,
    output logic [CNT_W-1:0]          done_cnt0,
    output logic [CNT_W-1:0]          done_cnt1
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
        $error("perceptron_arbiter: LATENCY must be in 1..15");
    end

    // Wait counter starts at LATENCY-1 so the class is captured exactly
    // LATENCY cycles after the core inputs change.
    localparam logic [WCNT_W-1:0] LAT_LOAD = WCNT_W'(LATENCY - 1);

    state_t              r_state;
    logic [WCNT_W-1:0]   r_cnt;
    logic [ID_W-1:0]     r_id;
    logic                r_favour;
    logic [SAMPLE_W-1:0] r_pe_in;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic                r_rsp_class;
    logic [CNT_W-1:0]    r_done0;
    logic [CNT_W-1:0]    r_done1;

    logic [N_REQ-1:0]    w_grant;
    logic                w_arb_en;
    logic [ID_W-1:0]     w_gid;

    // Grants are only offered from IDLE and never while reset is applied.
    assign w_arb_en = (r_state == IDLE) && !rst;
    assign w_gid    = w_grant[1];

    rr_arbiter2 u_arb (
        .req    (req_valid),
        .favour (r_favour),
        .en     (w_arb_en),
        .grant  (w_grant)
    );

    // Request acceptance, settle wait and response hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_id        <= '0;
            r_favour    <= 1'b0;
            r_pe_in     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_class <= 1'b0;
            r_done0     <= '0;
            r_done1     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_pe_in <= req_slice(req_data, w_gid);
                        r_id    <= w_gid;
                        r_cnt   <= LAT_LOAD;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_class <= pe_class;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - WCNT_W'(1);
                    end
                end
                RESP: begin
                    // Pointer moves on completion so a stalled response
                    // cannot let its own requester jump the queue.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_favour    <= ~r_id[0];
                        if (r_id[0]) begin
                            r_done1 <= r_done1 + CNT_W'(1);
                        end else begin
                            r_done0 <= r_done0 + CNT_W'(1);
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = w_grant;
    assign busy       = (r_state != IDLE) && !rst;
    assign pe_inputs1 = r_pe_in[PE_W-1:0];
    assign pe_inputs2 = r_pe_in[SAMPLE_W-1:PE_W];
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_class  = r_rsp_class;
    assign done_cnt0  = r_done0;
    assign done_cnt1  = r_done1;

endmodule

// File: tb/tb_perceptron_arbiter.sv
// Bench for perceptron_arbiter: directed table, multi-cycle corner
// sequences and a randomized run against a transaction-level model.
module tb_perceptron_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req_data;
    logic [1:0]  req_ready;
    logic [7:0]  pe_inputs1, pe_inputs2;
    logic        pe_class;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic        rsp_class;
    logic        rsp_ready;
    logic        busy;
    logic [7:0]  done_cnt0, done_cnt1;

    int n_cmp  = 0;
    int n_fail = 0;

    perceptron_arbiter #(.LATENCY(LAT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .pe_inputs1(pe_inputs1), .pe_inputs2(pe_inputs2), .pe_class(pe_class),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_class(rsp_class),
        .rsp_ready(rsp_ready), .busy(busy),
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    always #5 clk = ~clk;

    // Perceptron stand-in: class = inputs1 > inputs2, valid one register
    // stage (LAT-1) after the inputs change; earlier it shows the old class.
    logic pe_d;
    always @(posedge clk) pe_d <= (pe_inputs1 > pe_inputs2);
    assign pe_class = pe_d;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] data;
        logic [1:0]  exp_ready;
        logic [7:0]  exp_in1;
        logic [7:0]  exp_in2;
        logic        exp_cls;
    } vec_t;

    vec_t tbl[7];

    // Reference model state (transaction level: busy flag + cycles since grant).
    bit          m_busy;
    int          m_age;
    bit          m_id;
    logic [15:0] m_pe;
    bit          m_fav;
    logic [7:0]  m_cnt0, m_cnt1;

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_id = 0; m_pe = '0; m_fav = 0; m_cnt0 = '0; m_cnt1 = '0;
    endtask

    initial begin
        int   exp_c0, exp_c1, ng, found;
        bit   gid[8];
        int   gcy[8];
        int   nrsp;
        logic [1:0] e_ready;
        bit   e_valid;

        // Favour pointer after reset is 0; each completion flips it to !id.
        tbl[0] = '{2'b01, {16'h0000, 16'h3A5C}, 2'b01, 8'h5C, 8'h3A, 1'b1};
        tbl[1] = '{2'b11, {16'h2080, 16'h1111}, 2'b10, 8'h80, 8'h20, 1'b1};
        tbl[2] = '{2'b11, {16'hAAAA, 16'hF00F}, 2'b01, 8'h0F, 8'hF0, 1'b0};
        tbl[3] = '{2'b01, {16'hFFFF, 16'h7777}, 2'b01, 8'h77, 8'h77, 1'b0};
        tbl[4] = '{2'b10, {16'h0102, 16'h5555}, 2'b10, 8'h02, 8'h01, 1'b1};
        tbl[5] = '{2'b10, {16'hFF00, 16'h0000}, 2'b10, 8'h00, 8'hFF, 1'b0};
        tbl[6] = '{2'b11, {16'h9999, 16'h4321}, 2'b01, 8'h21, 8'h43, 1'b0};

        // ---------------- reset state ----------------
        rst = 1'b1; req_valid = 2'b11; req_data = '0; rsp_ready = 1'b1;
        next_cycle();
        sample();
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_busy", busy, 1'b0);
        next_cycle();
        rst = 1'b0; req_valid = 2'b00;
        sample();
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_class", rsp_class, 1'b0);
        chk("rst_pe", {pe_inputs2, pe_inputs1}, 16'h0000);
        chk("rst_cnt", {done_cnt1, done_cnt0}, 16'h0000);
        chk("rst_busy_after", busy, 1'b0);

        // ---------------- directed table ----------------
        exp_c0 = 0; exp_c1 = 0;
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            req_valid = tbl[i].rv; req_data = tbl[i].data; rsp_ready = 1'b1;
            sample();
            chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].exp_ready);
            next_cycle();
            req_valid = 2'b00; req_data = 32'hDEAD_BEEF;
            sample();
            chk($sformatf("tbl%0d_pe", i), {pe_inputs2, pe_inputs1}, {tbl[i].exp_in2, tbl[i].exp_in1});
            chk($sformatf("tbl%0d_busy", i), busy, 1'b1);
            for (int k = 2; k <= LAT; k++) begin
                next_cycle(); sample();
                chk($sformatf("tbl%0d_early_valid", i), rsp_valid, 1'b0);
            end
            next_cycle(); sample();
            chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid, 1'b1);
            chk($sformatf("tbl%0d_rsp_id", i), rsp_id, tbl[i].exp_ready[1]);
            chk($sformatf("tbl%0d_rsp_class", i), rsp_class, tbl[i].exp_cls);
            if (tbl[i].exp_ready[1]) exp_c1++; else exp_c0++;
            next_cycle(); sample();
            chk($sformatf("tbl%0d_idle", i), busy, 1'b0);
            chk($sformatf("tbl%0d_cnt0", i), done_cnt0, exp_c0);
            chk($sformatf("tbl%0d_cnt1", i), done_cnt1, exp_c1);
        end

        // ---------------- contention: strict alternation ----------------
        do_reset();
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            next_cycle();
            req_valid = 2'b11; req_data = $urandom; rsp_ready = 1'b1;
            sample();
            if (req_ready != 2'b00) begin
                gid[ng] = req_ready[1]; gcy[ng] = c; ng++;
            end
        end
        chk("cont_grants", ng, 6);
        for (int i = 0; i < ng; i++) begin
            chk($sformatf("cont_order%0d", i), gid[i], i % 2);
            if (i > 0) chk($sformatf("cont_gap%0d", i), gcy[i] - gcy[i-1], LAT + 2);
        end
        for (int k = 0; k < LAT + 2; k++) begin
            next_cycle(); req_valid = 2'b00;
        end
        sample();
        chk("cont_cnt0", done_cnt0, 3);
        chk("cont_cnt1", done_cnt1, 3);

        // ---------------- backpressure ----------------
        do_reset();
        next_cycle();
        rsp_ready = 1'b0; req_valid = 2'b01; req_data = {16'h0000, 16'h12C4};
        sample();
        chk("bp_ready", req_ready, 2'b01);
        next_cycle();
        req_valid = 2'b11; req_data = 32'hFFFF_FFFF;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (rsp_valid) begin found = 1; break; end
            next_cycle();
        end
        chk("bp_rsp_seen", found, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin next_cycle(); sample(); end
            chk($sformatf("bp_hold%0d", k), {rsp_valid, rsp_id, rsp_class, req_ready, pe_inputs2, pe_inputs1},
                {1'b1, 1'b0, 1'b1, 2'b00, 8'h12, 8'hC4});
        end
        next_cycle(); rsp_ready = 1'b1;
        sample();
        chk("bp_before_done", {rsp_valid, done_cnt0}, {1'b1, 8'd0});
        next_cycle(); sample();
        chk("bp_after_valid", rsp_valid, 1'b0);
        chk("bp_after_cnt0", done_cnt0, 8'd1);
        chk("bp_next_grant", req_ready, 2'b10);

        // ---------------- reset mid-WAIT ----------------
        next_cycle(); req_valid = 2'b00;
        sample();
        chk("mw_busy", busy, 1'b1);
        next_cycle(); rst = 1'b1; req_valid = 2'b11;
        sample();
        chk("mw_rst_ready", req_ready, 2'b00);
        chk("mw_rst_busy", busy, 1'b0);
        next_cycle(); rst = 1'b0;
        sample();
        chk("mw_rsp_valid", rsp_valid, 1'b0);
        chk("mw_pe", {pe_inputs2, pe_inputs1}, 16'h0000);
        chk("mw_cnt", {done_cnt1, done_cnt0}, 16'h0000);
        chk("mw_grant", req_ready, 2'b01);
        next_cycle(); req_valid = 2'b00;
        found = 0;
        for (int c = 0; c < 8; c++) begin
            sample();
            if (rsp_valid) begin found = 1; break; end
            next_cycle();
        end
        chk("mw_rsp_seen", found, 1);
        chk("mw_rsp_id", rsp_id, 1'b0);

        // ---------------- single requester + counter wrap ----------------
        do_reset();
        next_cycle(); req_valid = 2'b01; req_data = 32'h0000_0201; rsp_ready = 1'b1;
        ng = 0; nrsp = 0;
        for (int c = 0; c < 2000 && ng < 256; c++) begin
            next_cycle();
            req_valid = 2'b10; req_data = $urandom;
            sample();
            if (rsp_valid) begin
                chk("wrap_rsp_id", rsp_id, (nrsp == 0) ? 1'b0 : 1'b1);
                nrsp++;
            end
            if (req_ready != 2'b00) begin
                chk("wrap_grant", req_ready, 2'b10);
                if (ng < 8) gcy[ng] = c;
                ng++;
            end
        end
        for (int k = 0; k < LAT + 2; k++) begin
            next_cycle(); req_valid = 2'b00;
            sample();
            if (rsp_valid) begin
                chk("wrap_rsp_id", rsp_id, 1'b1);
                nrsp++;
            end
        end
        chk("wrap_grants", ng, 256);
        chk("wrap_rsps", nrsp, 257);
        chk("wrap_gap1", gcy[1] - gcy[0], LAT + 2);
        chk("wrap_gap2", gcy[2] - gcy[1], LAT + 2);
        chk("wrap_cnt1", done_cnt1, 8'd0);
        chk("wrap_cnt0", done_cnt0, 8'd1);

        // ---------------- randomized vs reference model ----------------
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            next_cycle();
            rst       = ($urandom_range(0, 79) == 0);
            req_valid = 2'($urandom_range(0, 3));
            req_data  = $urandom;
            rsp_ready = ($urandom_range(0, 2) != 0);
            sample();
            e_ready = 2'b00;
            if (!rst && !m_busy) begin
                if (req_valid == 2'b11) e_ready = m_fav ? 2'b10 : 2'b01;
                else                    e_ready = req_valid;
            end
            e_valid = m_busy && (m_age > LAT);
            chk("rnd_ready", req_ready, e_ready);
            chk("rnd_busy", busy, !rst && m_busy);
            chk("rnd_valid", rsp_valid, e_valid);
            if (e_valid) begin
                chk("rnd_id", rsp_id, m_id);
                chk("rnd_class", rsp_class, m_pe[7:0] > m_pe[15:8]);
            end
            chk("rnd_pe", {pe_inputs2, pe_inputs1}, m_pe);
            chk("rnd_cnt", {done_cnt1, done_cnt0}, {m_cnt1, m_cnt0});
            if (rst) begin
                model_reset();
            end else if (m_busy) begin
                if (e_valid && rsp_ready) begin
                    m_busy = 0;
                    if (m_id) m_cnt1 = m_cnt1 + 8'd1; else m_cnt0 = m_cnt0 + 8'd1;
                    m_fav = !m_id;
                end else begin
                    m_age++;
                end
            end else if (e_ready != 2'b00) begin
                m_busy = 1; m_age = 1; m_id = e_ready[1];
                m_pe = e_ready[1] ? req_data[31:16] : req_data[15:0];
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/perceptron_arbiter.md
Name: perceptron_arbiter

Overview:
Shares one perceptron datapath between two requesters (host port 0, host port 1) using round-robin arbitration. Each accepted request carries one 16-bit sample (two 8-bit input vectors). The block drives the sample onto the perceptron inputs and holds it for the datapath settle time. It then captures the 1-bit classification and returns it, tagged with the requester ID, over a valid/ready response channel. It sits between the top-level pin wrapper and the perceptron core.

Parameters:
LATENCY, 2, cycles from perceptron inputs being driven to classification valid; legal range 1..15
CNT_W, 8, width of per-requester completion counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
req_valid  input  2  bit i: requester i has a sample pending
req_data  input  32  [15:0] requester 0, [31:16] requester 1; per slice, [7:0]=inputs1, [15:8]=inputs2
req_ready  output  2  bit i: requester i's sample accepted this cycle (one-hot or zero)
pe_inputs1  output  8  to perceptron inputs1
pe_inputs2  output  8  to perceptron inputs2
pe_class  input  1  classification from perceptron
rsp_valid  output  1  response available
rsp_id  output  1  requester that owns the response
rsp_class  output  1  captured classification
rsp_ready  input  1  downstream accepts response
busy  output  1  high in any state other than IDLE
done_cnt0  output  CNT_W  completed responses for requester 0
done_cnt1  output  CNT_W  completed responses for requester 1

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, rr pointer favours requester 0, pe_inputs1/2=0, rsp_valid=0, rsp_id=0, rsp_class=0, done_cnt0/1=0, wait counter=0. req_ready=0 and busy=0 during reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready is combinational from req_valid and the rr pointer.
  - If exactly one req_valid bit is set, grant that requester.
  - If both are set, grant the requester the pointer favours.
  - Grant g asserts req_ready[g] in this cycle (the handshake cycle T). At the edge ending T: pe_inputs <= req_data slice g, latch id=g, counter<=LATENCY-1, go to WAIT.
  - No req_valid: stay in IDLE; pe_inputs retain their last value.
- WAIT:
  - req_ready=0.
  - If counter==0: rsp_class<=pe_class, rsp_id<=id, rsp_valid<=1, go to RESP.
  - Otherwise decrement counter.
  - pe_class is sampled exactly LATENCY cycles after pe_inputs change, so rsp_valid first rises at T+LATENCY+1.
- RESP:
  - rsp_valid=1; rsp_id and rsp_class held stable.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, increment done_cnt[id] (wraps at 2^CNT_W), pointer<=favour !id, go to IDLE.
  - Otherwise hold indefinitely (backpressure).
- pe_inputs are stable from T+1 through the end of RESP.
- Throughput: one transaction per LATENCY+2 cycles when rsp_ready is tied high.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- The pointer updates only on response completion, not on grant.
- A single active requester is granted back-to-back regardless of the pointer.
- req_data changes while req_ready is low are ignored. A requester may deassert req_valid before grant without effect.
- Reset mid-transaction (WAIT or RESP): the transaction is dropped, no response is emitted, counters clear, and the next grant follows the reset pointer (requester 0).
- LATENCY outside 1..15: compile-time error via an elaboration check.

Decomposition:
- Package perceptron_pkg: N_REQ=2, ID_W=1, SAMPLE_W=16, state enum {IDLE, WAIT, RESP}, and a slice helper for req_data.
- Sub-module rr_arbiter2: inputs req[1:0], favour, en; output grant[1:0] (one-hot or zero); purely combinational.
- The FSM, counters, and datapath registers live in perceptron_arbiter.

Test Plan:
- Single request, LATENCY=2: req_valid=2'b01, req_data[15:0]=16'h3A5C at cycle T.
  - Expect req_ready=2'b01 at T; pe_inputs1=8'h5C and pe_inputs2=8'h3A from T+1.
  - With the pe model returning 1: rsp_valid rises at T+3, rsp_id=0, rsp_class=1, done_cnt0=1 after the handshake.
- Contention: req_valid=2'b11 held, rsp_ready=1, for 6 transactions.
  - Grant order must be 0,1,0,1,0,1, with one grant every 4 cycles.
  - Final done_cnt0=3, done_cnt1=3.
- Backpressure: rsp_ready=0 for 5 cycles once rsp_valid is high.
  - rsp_valid, rsp_id, rsp_class and pe_inputs stay constant; req_ready stays 0.
  - Completion occurs on the cycle rsp_ready rises.
- Reset mid-WAIT: assert rst for 1 cycle during WAIT.
  - Next cycle: state IDLE, rsp_valid=0, pe_inputs=0, counters=0.
  - No response for the dropped sample; with req_valid=2'b11, the next grant goes to requester 0.
- Counter wrap: run 256 requester-1 transactions → done_cnt1=0, done_cnt0 unchanged.
- Single active requester: req_valid=2'b10 held for 3 transactions → all granted to requester 1, back-to-back, with rsp_id=1 each time.
